// File: rtl/bk_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor (diff = a - b) processing one 4-bit slice per clock
// through a Brent-Kung prefix carry network, with a registered carry between slices.
module bk_serial_subtractor #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NSLICE = WIDTH / 4;
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] bn_q, bn_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  // Current slice operands, selected by shifting so no part-select can run out of range
  logic [CNT_W+1:0] slice_sh;
  logic [WIDTH-1:0] a_sh, bn_sh;
  logic [3:0]       sa, sb;

  always_comb begin
    slice_sh = {cnt_q, 2'b00};
    a_sh     = a_q >> slice_sh;
    bn_sh    = bn_q >> slice_sh;
    sa       = a_sh[3:0];
    sb       = bn_sh[3:0];
  end

  // 4-bit Brent-Kung prefix carry network for one slice
  logic [3:0] p, g, sum;
  logic       g10, p10, g32, p32, g30, p30, g20, p20;
  logic       c1, c2, c3, cout;

  always_comb begin
    p    = sa ^ sb;
    g    = sa & sb;
    g10  = g[1] | (p[1] & g[0]);
    p10  = p[1] & p[0];
    g32  = g[3] | (p[3] & g[2]);
    p32  = p[3] & p[2];
    g30  = g32 | (p32 & g10);
    p30  = p32 & p10;
    g20  = g[2] | (p[2] & g10);
    p20  = p[2] & p10;
    c1   = g[0] | (p[0] & carry_q);
    c2   = g10 | (p10 & carry_q);
    c3   = g20 | (p20 & carry_q);
    cout = g30 | (p30 & carry_q);
    sum  = p ^ {c3, c2, c1, carry_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      bn_q        <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b1;
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      bn_q        <= bn_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      diff_q      <= diff_d;
      borrow_q    <= borrow_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic; results are copied to the outputs only on the last slice,
  // so the held result stays intact while the next operation runs
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    bn_d     = bn_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          bn_d    = ~b;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = (acc_q & ~(WIDTH'(4'hF) << slice_sh)) | (WIDTH'(sum) << slice_sh);
        carry_d = cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_SLICE) begin
          diff_d   = acc_d;
          borrow_d = ~cout;
          ovf_d    = c3 ^ cout;
          zero_d   = (acc_d == '0);
          cnt_d    = '0;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_bk_serial_subtractor.sv
// Self-checking bench for bk_serial_subtractor: directed vector table, multi-cycle
// corner sequences (stall, mid-run reset) and a randomized sweep against a reference model.
module tb_bk_serial_subtractor;

  localparam int unsigned W      = 16;
  localparam int unsigned NSLICE = W / 4;
  localparam int unsigned BOUND  = 3 * NSLICE + 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int errors = 0;
  int checks = 0;

  bk_serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .borrow    (borrow),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
    logic         zero;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: plain modular arithmetic and signed-range reasoning
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] d, output logic br, output logic ov,
                       output logic z);
    longint sx, sy, sd;
    d  = x - y;
    br = (x < y);
    sx = (x[W-1]) ? longint'(x) - (longint'(1) <<< W) : longint'(x);
    sy = (y[W-1]) ? longint'(y) - (longint'(1) <<< W) : longint'(y);
    sd = sx - sy;
    ov = (sd > (longint'(1) <<< (W - 1)) - 1) || (sd < -(longint'(1) <<< (W - 1)));
    z  = (d == '0);
  endtask

  // One full transaction; stall = cycles out_ready is held low once the result is up
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input int stall,
                    output logic [W-1:0] rd, output logic rbr, output logic rov,
                    output logic rz, output int lat);
    @(negedge clk);
    a         = ta;
    b         = tbv;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    lat      = 0;
    while (!out_valid && lat < int'(BOUND)) begin
      @(posedge clk);
      #1;
      lat++;
      in_valid = 1'($urandom);
      chk("in_ready_busy", 64'(in_ready), out_valid ? 64'(0) : 64'(0));
    end
    in_valid = 1'b0;
    rd  = diff;
    rbr = borrow;
    rov = ovf;
    rz  = zero;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_diff", 64'(diff), 64'(rd));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drop", 64'(out_valid), 64'd0);
    chk("in_ready_back", 64'(in_ready), 64'd1);
  endtask

  vec_t         vecs[9];
  logic [W-1:0] rd, md;
  logic         rbr, rov, rz, mbr, mov, mz;
  int           lat;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    vecs[0] = '{16'h1234, 16'h0234, 16'h1000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{16'hA5A5, 16'hA5A5, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{16'h0001, 16'hFFFF, 16'h0002, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{16'h0000, 16'h8000, 16'h8000, 1'b1, 1'b1, 1'b0};

    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_diff", 64'(diff), 64'd0);
    chk("rst_flags", 64'({borrow, ovf, zero}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      op(vecs[i].a, vecs[i].b, 0, rd, rbr, rov, rz, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(NSLICE));
      chk($sformatf("vec%0d_diff", i), 64'(rd), 64'(vecs[i].diff));
      chk($sformatf("vec%0d_borrow", i), 64'(rbr), 64'(vecs[i].borrow));
      chk($sformatf("vec%0d_ovf", i), 64'(rov), 64'(vecs[i].ovf));
      chk($sformatf("vec%0d_zero", i), 64'(rz), 64'(vecs[i].zero));
    end

    // Asynchronous reset mid-cycle with two slices already done
    @(negedge clk);
    a         = 16'h1234;
    b         = 16'h0001;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_diff", 64'(diff), 64'd0);
    chk("midrst_borrow", 64'(borrow), 64'd0);
    chk("midrst_ovf", 64'(ovf), 64'd0);
    chk("midrst_zero", 64'(zero), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    op(16'h0005, 16'h0003, 0, rd, rbr, rov, rz, lat);
    chk("postrst_latency", 64'(lat), 64'(NSLICE));
    chk("postrst_diff", 64'(rd), 64'h2);
    chk("postrst_flags", 64'({rbr, rov, rz}), 64'd0);

    // Result held for 5 cycles with out_ready low; new requests must be ignored
    @(negedge clk);
    a         = 16'hA5A5;
    b         = 16'hA5A5;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat      = 0;
    while (!out_valid && lat < int'(BOUND)) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("hold_latency", 64'(lat), 64'(NSLICE));
    chk("hold_diff", 64'(diff), 64'd0);
    chk("hold_zero", 64'(zero), 64'd1);
    chk("hold_borrow", 64'(borrow), 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_out_valid", 64'(out_valid), 64'd1);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_diff_stable", 64'(diff), 64'd0);
      chk("hold_zero_stable", 64'(zero), 64'd1);
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_valid", 64'(out_valid), 64'd0);
    chk("hold_release_ready", 64'(in_ready), 64'd1);
    #10;
    chk("hold_no_queued_op", 64'(in_ready), 64'd1);

    // Randomized sweep against the reference model
    for (int n = 0; n < 1500; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      if (n % 50 == 0) rb = ra;
      if (n % 50 == 1) rb = ra + W'(1);
      model(ra, rb, md, mbr, mov, mz);
      op(ra, rb, int'($urandom_range(0, 2)), rd, rbr, rov, rz, lat);
      chk("rand_latency", 64'(lat), 64'(NSLICE));
      chk("rand_diff", 64'(rd), 64'(md));
      chk("rand_borrow", 64'(rbr), 64'(mbr));
      chk("rand_ovf", 64'(rov), 64'(mov));
      chk("rand_zero", 64'(rz), 64'(mz));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
